one_four_demux_reg: RTL
=======================

Name: one_four_demux_reg

Overview:
- Registered 1-to-4 byte demultiplexer: the write-side counterpart of the 4:1 byte select mux on the datapath.
- Accepts one byte plus a 2-bit destination selector over a valid/ready handshake.
- Holds the byte in a one-entry buffer and presents it to exactly one of four output channels, each with its own valid/ready handshake.
- Keeps a per-channel delivered-byte counter for debug and status.

Parameters:
DATA_W, 8, width of each data byte/word
CNT_W, 8, width of each per-channel delivery counter

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  upstream has a byte to route
in_ready  output  1  block can accept a byte this cycle
in_sel  input  2  destination channel: 00=ch0, 01=ch1, 10=ch2, 11=ch3
in_data  input  DATA_W  byte to route
out_valid  output  4  one-hot per-channel valid, bit i = channel i
out_ready  input  4  per-channel ready, bit i = channel i
out_data0  output  DATA_W  channel 0 data
out_data1  output  DATA_W  channel 1 data
out_data2  output  DATA_W  channel 2 data
out_data3  output  DATA_W  channel 3 data
busy  output  1  buffer holds an undelivered byte
cnt0..cnt3  output  CNT_W each  bytes delivered on channel i

Behaviour:
- One clock (clk). Reset is asynchronous and active-low (rst_n). All state changes happen on the rising edge of clk.
- While rst_n is asserted (low):
  - State = EMPTY.
  - out_valid = 4'b0000, busy = 0, in_ready = 1 once rst_n deasserts.
  - out_data0..3 = 0, cnt0..3 = 0.
- States:
  - EMPTY: no byte buffered.
  - FULL: one byte buffered; sel_q/data_q registered.
- Input handshake: a byte is accepted when in_valid && in_ready at the clock edge.
- Output handshake on channel i: delivery occurs when out_valid[i] && out_ready[i] at the clock edge.
- in_ready is combinational:
  - EMPTY: in_ready = 1.
  - FULL: in_ready = out_ready[sel_q], allowing a same-cycle deliver+accept.
  - in_ready must not depend on in_valid.
- EMPTY transitions:
  - Accept -> FULL. Latch sel_q = in_sel; load out_data[in_sel] = in_data.
  - No accept -> stay EMPTY.
- FULL transitions:
  - Delivery without accept -> EMPTY; cnt[sel_q] increments.
  - Delivery with accept -> stay FULL. cnt[sel_q] increments; sel_q and out_data[in_sel] reload from the new byte. The new selector may equal or differ from the old one.
  - No delivery -> stay FULL. Buffered byte and sel_q remain stable; in_ready = 0.
- Latency: a byte accepted at edge N is visible on out_valid/out_data at cycle N+1. Sustained throughput is 1 byte/cycle to the same or alternating channels while the consumer keeps ready high.
- out_valid:
  - FULL: out_valid = one-hot(sel_q).
  - EMPTY: out_valid = 0.
  - At most one bit is ever set.
- Non-selected outputs: out_data of non-selected channels holds its last delivered value and is never cleared except by reset.
- Valid-hold rule: once out_valid[i] rises, it and out_data_i stay stable until delivery. No withdrawal, no change of data.
- Ready on idle channels: out_ready bits of non-selected channels are ignored.
- Counters: cnt_i increments by 1 per delivery on channel i and wraps modulo 2^CNT_W (all-ones -> 0) without flagging.
- busy = (state == FULL).
- Reset mid-operation: asserting rst_n low while FULL immediately drops out_valid and busy and discards the buffered byte; no counter increments.
- Input selector: in_sel is sampled only on accept. X or changes on in_sel/in_data while in_valid = 0 have no effect.

Test Plan:
- Reset then idle: hold in_valid = 0 for 10 cycles -> out_valid = 0000, busy = 0, in_ready = 1, all cnt = 0, all out_data = 0.
- Single route: send in_sel = 10, in_data = 8'hA5, out_ready = 1111 -> next cycle out_valid = 0100, out_data2 = A5; after delivery cnt2 = 1, busy = 0, out_data2 still A5.
- Backpressure: send sel = 01, data = 3C with out_ready = 0000 for 5 cycles:
  - out_valid = 0010 held and out_data1 = 3C stable throughout; in_ready = 0, and a second offered byte is not accepted.
  - Raise out_ready[1] -> delivery; cnt1 = 1.
- Back-to-back streaming: bytes 01,02,03,04 with sels 00,01,10,11 on consecutive cycles, out_ready = 1111 -> in_ready stays 1; out_valid steps 0001,0010,0100,1000 on consecutive cycles; each cnt = 1; out_data0..3 = 01,02,03,04.
- Wrong-channel ready: buffered byte for ch3, out_ready = 0111 -> no delivery, state stays FULL, counters unchanged.
- Counter wrap and reset mid-op: deliver 256 bytes to ch0 with CNT_W = 8 -> cnt0 = 0. Then buffer a byte for ch2 and pulse rst_n low -> out_valid = 0000 immediately, cnt2 = 0, busy = 0.

Source files
------------

// File: rtl/one_four_demux_reg.sv
// one_four_demux_reg: registered 1-to-4 byte demux with a one-entry buffer,
// per-channel valid/ready handshakes and per-channel delivery counters.
module one_four_demux_reg #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        in_sel,
    input  logic [DATA_W-1:0] in_data,
    output logic [3:0]        out_valid,
    input  logic [3:0]        out_ready,
    output logic [DATA_W-1:0] out_data0,
    output logic [DATA_W-1:0] out_data1,
    output logic [DATA_W-1:0] out_data2,
    output logic [DATA_W-1:0] out_data3,
    output logic              busy,
    output logic [CNT_W-1:0]  cnt0,
    output logic [CNT_W-1:0]  cnt1,
    output logic [CNT_W-1:0]  cnt2,
    output logic [CNT_W-1:0]  cnt3
);
    typedef enum logic {EMPTY, FULL} state_t;

    state_t            r_state;
    state_t            w_next;
    logic [1:0]        r_sel;
    logic [DATA_W-1:0] r_data [4];
    logic [CNT_W-1:0]  r_cnt  [4];
    logic              w_deliver;
    logic              w_accept;

    always_comb begin
        w_deliver = (r_state == FULL) && out_ready[r_sel];
        in_ready  = (r_state == EMPTY) || out_ready[r_sel];
        w_accept  = in_valid && in_ready;
        // an accept in FULL implies a same-cycle delivery, so the buffer stays FULL
        w_next    = w_accept ? FULL : (w_deliver ? EMPTY : r_state);
        out_valid = (r_state == FULL) ? (4'b0001 << r_sel) : 4'b0000;
        busy      = (r_state == FULL);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= EMPTY;
        else        r_state <= w_next;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sel <= 2'b00;
            for (int k = 0; k < 4; k++) begin
                r_data[k] <= '0;
                r_cnt[k]  <= '0;
            end
        end else begin
            if (w_deliver) r_cnt[r_sel] <= r_cnt[r_sel] + 1'b1;
            if (w_accept) begin
                r_sel          <= in_sel;
                r_data[in_sel] <= in_data;
            end
        end
    end

    assign out_data0 = r_data[0];
    assign out_data1 = r_data[1];
    assign out_data2 = r_data[2];
    assign out_data3 = r_data[3];
    assign cnt0      = r_cnt[0];
    assign cnt1      = r_cnt[1];
    assign cnt2      = r_cnt[2];
    assign cnt3      = r_cnt[3];
endmodule
